// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline types: data width, default fetch-queue depth and the
// {pc, inst} record that travels from IF to ID.
package rv_pkg;

  localparam int XLEN     = 32;
  localparam int IQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage : rv_pkg

// File: rtl/if_fetch_queue.sv
// IF->ID fetch queue: buffers up to DEPTH {pc, inst} words captured from IF,
// presents the oldest to decode with valid/ready, stalls IF when full and
// empties itself on a branch redirect.
module if_fetch_queue
  import rv_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_inst,
  input  logic             br_ctrl,
  output logic             pc_stall,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_inst,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  fetch_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   full;
  logic                   empty;
  logic                   enq;
  logic                   deq;
  fetch_entry_t           head;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Handshake decode: a redirect overrides both sides; the stall comes from the
  // registered count, so a full queue never bypasses a fetch into a freed slot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    pc_stall = 1'b0;
    enq      = 1'b0;
    deq      = 1'b0;
    id_valid = ~empty;
    head     = mem[rd_ptr];
    id_pc    = '0;
    id_inst  = '0;
    if (!br_ctrl) begin
      pc_stall = full;
      enq      = ~rst & ~full;
      deq      = id_valid & id_ready;
    end
    if (id_valid) begin
      id_pc   = head.pc;
      id_inst = head.inst;
    end
  end

  // Pointer and occupancy update: reset beats redirect, redirect beats enq/deq.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst || br_ctrl) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (deq) rd_ptr <= rd_ptr + PTR_ONE;
      if (enq && !deq)      count <= count + CNT_ONE;
      else if (deq && !enq) count <= count - CNT_ONE;
    end
  end

  // Entry storage: write the word IF is presenting at the tail slot.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately left out of reset; the count and id_valid
    // gating keep stale entries from ever being observed.
    if (enq) mem[wr_ptr] <= '{pc: if_pc, inst: if_inst};
  end

  // Overflow and underflow can only happen if the gating above is broken.
  assert property (@(posedge clk) disable iff (rst) !(enq && full));
  assert property (@(posedge clk) disable iff (rst) !(deq && empty));
  assert property (@(posedge clk) disable iff (rst) count <= CNT_FULL);

endmodule : if_fetch_queue
